accu_cfg_sequencer: RTL and testbench
=====================================

ACCU_CFG_SEQUENCER -- requirements
Module: accu_cfg_sequencer

Interface
REQ-001 The block SHALL have one clock, ACLK; reset ARESET SHALL be synchronous and active-high.
REQ-002 The block SHALL have these parameters:
- ADDR_W, default 4: AXI4-Lite address width.
- BASE_ADDR, default 0: byte address of register 0 of the accumulator slave.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- ACLK  in  1  clock
- ARESET  in  1  sync active-high reset
- start  in  1  one-cycle request to run a sequence
- cfg_data  in  128  four 32-bit words; word i = bits [32i+31:32i]
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- pass  out  1  last sequence had no errors
- err_cnt  out  4  errors in last or current sequence
- m_axi_awaddr  out  ADDR_W  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  write strobes, constant 4'hF
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  ADDR_W  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

Function
REQ-004 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, with a 2-bit word index idx.
REQ-005 In IDLE with start=1, the block SHALL latch cfg_data, clear err_cnt and idx, set busy, and enter WR_REQ next cycle.
REQ-006 start SHALL be ignored when busy=1.
REQ-007 WR_REQ:
- awvalid and wvalid SHALL assert together, with awaddr = BASE_ADDR + 4*idx and wdata = word idx.
- Each valid SHALL deassert the cycle after its own handshake; handshakes MAY complete in either order or in the same cycle.
- When both handshakes are done, the FSM SHALL enter WR_RESP.
REQ-008 WR_RESP:
- bready SHALL be 1.
- On bvalid, bresp != 2'b00 SHALL increment err_cnt.
- If idx = 3, the FSM SHALL clear idx and enter RD_REQ; otherwise it SHALL increment idx and return to WR_REQ.
REQ-009 RD_REQ: arvalid SHALL be 1 with araddr = BASE_ADDR + 4*idx until arready, then the FSM SHALL enter RD_RESP.
REQ-010 RD_RESP:
- rready SHALL be 1.
- On rvalid, rdata != word idx, or rresp != 2'b00, SHALL increment err_cnt once per beat.
- If idx = 3, the FSM SHALL enter DONE; otherwise it SHALL increment idx and enter RD_REQ.
REQ-011 err_cnt SHALL saturate at 15.
REQ-012 DONE SHALL last one cycle: done=1, pass=(err_cnt==0), busy=0, then the FSM SHALL return to IDLE.
REQ-013 pass and err_cnt SHALL hold their values until the next accepted start.
REQ-014 Only one AXI transaction SHALL be outstanding at any time.
REQ-015 All valid outputs SHALL be registered, and payloads SHALL be stable while valid=1 and ready=0.

Reset
REQ-016 On ARESET, the FSM SHALL go to IDLE, and idx, err_cnt, busy, done, pass, all valids, bready and rready SHALL be 0.
REQ-017 A reset mid-sequence SHALL abandon the sequence without a done pulse; the environment resets the slave concurrently.

Structure
REQ-018 Package accu_seq_pkg SHALL hold the state enum, N_REGS=4, and RESP_OKAY=2'b00.
REQ-019 The block SHALL be a single module with no sub-module.

Verification
REQ-020 start, cfg_data={4,3,2,1}, zero-wait slave -> writes 1,2,3,4 to 0x0/0x4/0x8/0xC, reads match, done pulses once, pass=1, err_cnt=0.
REQ-021 Slave returns 0xDEAD for register 2 read -> err_cnt=1, pass=0.
REQ-022 awready delayed 3 cycles, wready immediate -> wvalid high exactly 1 cycle, awvalid held 4 cycles, exactly one write per register.
REQ-023 bresp=2'b10 on write 0 -> err_cnt=1, all 8 transactions still issued, pass=0.
REQ-024 start re-pulsed during RD_REQ -> ignored; exactly 8 transactions issued and one done pulse.
REQ-025 ARESET during RD_RESP -> next cycle all outputs 0; a subsequent start completes a full pass=1 sequence.

Source files
------------

// File: rtl/accu_cfg_sequencer_pkg.sv
// Shared types and constants for the accumulator configuration sequencer.
package accu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam int         N_REGS    = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/accu_cfg_sequencer.sv
// Writes four configuration words to an AXI4-Lite accumulator slave, reads
// them back, and reports how many write responses / read beats were bad.
module accu_cfg_sequencer
    import accu_seq_pkg::*;
#(
    parameter int              ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [127:0]      cfg_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3:0]        err_cnt,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam logic [1:0] IDX_LAST = 2'(N_REGS - 1);
    localparam logic [3:0] ERR_MAX  = 4'd15;

    // Error counter increments stick at the top value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == ERR_MAX) ? v : v + 4'd1;
    endfunction

    // Byte address of register idx within the slave.
    function automatic logic [ADDR_W-1:0] reg_addr(input logic [1:0] idx);
        return BASE_ADDR + ADDR_W'({idx, 2'b00});
    endfunction

    state_e        r_state;
    state_e        w_state_nxt;
    logic [127:0]  r_cfg;
    logic [1:0]    r_idx;
    logic [3:0]    r_err;
    logic          r_busy, r_done, r_pass;
    logic          r_awvalid, r_wvalid, r_aw_ok, r_w_ok;
    logic          r_arvalid, r_bready, r_rready;

    logic [1:0]    w_idx_nxt;
    logic [3:0]    w_err_nxt;
    logic          w_busy_nxt, w_done_nxt, w_pass_nxt;
    logic          w_awvalid_nxt, w_wvalid_nxt, w_aw_ok_nxt, w_w_ok_nxt;
    logic          w_arvalid_nxt, w_bready_nxt, w_rready_nxt;
    logic          w_latch;

    logic [31:0]   w_word;
    logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic          w_wr_both;
    logic          w_rd_bad;
    logic [3:0]    w_rd_err;

    assign w_word    = r_cfg[{r_idx, 5'b00000} +: 32];
    assign w_aw_hs   = r_awvalid & m_axi_awready;
    assign w_w_hs    = r_wvalid & m_axi_wready;
    assign w_b_hs    = r_bready & m_axi_bvalid;
    assign w_ar_hs   = r_arvalid & m_axi_arready;
    assign w_r_hs    = r_rready & m_axi_rvalid;
    // Address and data phases may finish in either order; either may already be done.
    assign w_wr_both = (r_aw_ok | w_aw_hs) & (r_w_ok | w_w_hs);
    assign w_rd_bad  = (m_axi_rdata != w_word) | (m_axi_rresp != RESP_OKAY);
    assign w_rd_err  = w_rd_bad ? sat_inc(r_err) : r_err;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode: one AXI transaction at a time, writes then reads.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start && !r_busy) w_state_nxt = WR_REQ;
            WR_REQ:  if (w_wr_both)        w_state_nxt = WR_RESP;
            WR_RESP: if (w_b_hs)           w_state_nxt = (r_idx == IDX_LAST) ? RD_REQ : WR_REQ;
            RD_REQ:  if (w_ar_hs)          w_state_nxt = RD_RESP;
            RD_RESP: if (w_r_hs)           w_state_nxt = (r_idx == IDX_LAST) ? DONE : RD_REQ;
            DONE:                          w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // Output decode: next values of the registered handshake and status outputs.
    always_comb begin
        w_idx_nxt     = r_idx;
        w_err_nxt     = r_err;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = r_pass;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_aw_ok_nxt   = r_aw_ok;
        w_w_ok_nxt    = r_w_ok;
        w_arvalid_nxt = r_arvalid;
        w_bready_nxt  = r_bready;
        w_rready_nxt  = r_rready;
        w_latch       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_busy) begin
                    w_latch       = 1'b1;
                    w_idx_nxt     = '0;
                    w_err_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_aw_ok_nxt   = 1'b0;
                    w_w_ok_nxt    = 1'b0;
                end
            end
            WR_REQ: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_ok_nxt   = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_ok_nxt   = 1'b1;
                end
                if (w_wr_both) w_bready_nxt = 1'b1;
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt = 1'b0;
                    if (m_axi_bresp != RESP_OKAY) w_err_nxt = sat_inc(r_err);
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt     = '0;
                        w_arvalid_nxt = 1'b1;
                    end else begin
                        w_idx_nxt     = r_idx + 2'd1;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_ok_nxt   = 1'b0;
                        w_w_ok_nxt    = 1'b0;
                    end
                end
            end
            RD_REQ: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            RD_RESP: begin
                if (w_r_hs) begin
                    w_rready_nxt = 1'b0;
                    w_err_nxt    = w_rd_err;
                    if (r_idx == IDX_LAST) begin
                        w_done_nxt = 1'b1;
                        w_busy_nxt = 1'b0;
                        w_pass_nxt = (w_rd_err == 4'd0);
                    end else begin
                        w_idx_nxt     = r_idx + 2'd1;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Control and status registers, cleared by reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_idx     <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_w_ok    <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_aw_ok   <= w_aw_ok_nxt;
            r_w_ok    <= w_w_ok_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_rready  <= w_rready_nxt;
        end
    end

    // Configuration words captured on an accepted start; payload only, no reset.
    always_ff @(posedge ACLK) begin
        if (w_latch) r_cfg <= cfg_data;
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err;
    assign m_axi_awaddr  = reg_addr(r_idx);
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = w_word;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = reg_addr(r_idx);
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_accu_cfg_sequencer.sv
// Bench for accu_cfg_sequencer: table of directed sequences, randomized
// sequences scored against a transaction-level model, and a reset corner case.
module tb_accu_cfg_sequencer;

    typedef struct {
        logic [127:0] cfg;
        int           awd;
        int           wd;
        int           ard;
        logic [3:0]   be;
        logic [3:0]   rb;
        logic [3:0]   re;
        int           exp_err;
        bit           rep;
    } vec_t;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, pass;
    logic [3:0]   err_cnt;
    logic [3:0]   m_axi_awaddr, m_axi_araddr;
    logic         m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
    logic [31:0]  m_axi_wdata;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic [1:0]   m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic         m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [31:0]  m_axi_rdata = '0;

    accu_cfg_sequencer dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial forever #5 ACLK = ~ACLK;

    // Slave configuration and state
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [3:0]  b_err_m = '0, r_bad_m = '0, r_err_m = '0;
    logic [31:0] mem [4];
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic        aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [3:0]  aw_a = '0;
    logic [31:0] w_d = '0;
    logic [1:0]  b_reg = '0, r_reg = '0;
    logic        aw_hold = 0, w_hold = 0;
    logic [3:0]  aw_hold_a = '0;
    logic [31:0] w_hold_d = '0;
    logic [35:0] wr_q [$];
    logic [3:0]  rd_q [$];
    int          done_cnt = 0, wv_cyc = 0, av_cyc = 0, ovl = 0, stab_bad = 0;

    int n_vec = 0;
    int n_bad = 0;

    // Monitor: sees pre-edge DUT outputs at each rising edge, logs transactions.
    initial forever begin
        @(posedge ACLK);
        if (ARESET) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; aw_hold = 0; w_hold = 0;
        end else begin
            if ((m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) && (b_pend || r_pend)) ovl++;
            if ((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid) ovl++;
            if (aw_hold && m_axi_awvalid && m_axi_awaddr != aw_hold_a) stab_bad++;
            if (w_hold && m_axi_wvalid && m_axi_wdata != w_hold_d) stab_bad++;
            aw_hold = m_axi_awvalid && !m_axi_awready; aw_hold_a = m_axi_awaddr;
            w_hold  = m_axi_wvalid && !m_axi_wready;   w_hold_d  = m_axi_wdata;
            if (m_axi_awvalid) av_cyc++;
            if (m_axi_wvalid) wv_cyc++;
            if (done) done_cnt++;
            if (m_axi_bvalid && m_axi_bready) b_pend = 0;
            if (m_axi_rvalid && m_axi_rready) r_pend = 0;
            if (m_axi_awvalid) begin
                if (m_axi_awready) begin aw_got = 1; aw_a = m_axi_awaddr; aw_wait = 0; end
                else aw_wait++;
            end
            if (m_axi_wvalid) begin
                if (m_axi_wready) begin w_got = 1; w_d = m_axi_wdata; w_wait = 0; end
                else w_wait++;
            end
            if (aw_got && w_got) begin
                mem[aw_a[3:2]] = w_d;
                wr_q.push_back({aw_a, w_d});
                b_reg = aw_a[3:2]; b_pend = 1; aw_got = 0; w_got = 0;
            end
            if (m_axi_arvalid) begin
                if (m_axi_arready) begin
                    r_reg = m_axi_araddr[3:2]; rd_q.push_back(m_axi_araddr); r_pend = 1; ar_wait = 0;
                end else ar_wait++;
            end
        end
    end

    // Slave driver: updates ready/response signals mid-cycle.
    initial forever begin
        @(negedge ACLK);
        m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
        m_axi_wready  = m_axi_wvalid && (w_wait >= w_dly);
        m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
        m_axi_bvalid  = b_pend;
        m_axi_bresp   = b_err_m[b_reg] ? 2'b10 : 2'b00;
        m_axi_rvalid  = r_pend;
        m_axi_rdata   = r_bad_m[r_reg] ? 32'h0000DEAD : mem[r_reg];
        m_axi_rresp   = r_err_m[r_reg] ? 2'b10 : 2'b00;
    end

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: count bad write responses plus bad read beats, saturating.
    function automatic int model_err(input logic [127:0] cfg, input logic [3:0] be,
                                     input logic [3:0] rb, input logic [3:0] re);
        int e = 0;
        logic [31:0] word, got;
        for (int i = 0; i < 4; i++) begin
            word = cfg[32*i +: 32];
            if (be[i]) e++;
            got = rb[i] ? 32'h0000DEAD : word;
            if (got != word || re[i]) e++;
        end
        return (e > 15) ? 15 : e;
    endfunction

    task automatic clear_logs();
        wr_q.delete(); rd_q.delete();
        done_cnt = 0; wv_cyc = 0; av_cyc = 0; ovl = 0; stab_bad = 0;
    endtask

    task automatic pulse_start(input logic [127:0] cfg);
        @(negedge ACLK);
        cfg_data = cfg; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0; cfg_data = ~cfg;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int t;
        logic [3:0] a;
        aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard;
        b_err_m = v.be; r_bad_m = v.rb; r_err_m = v.re;
        clear_logs();
        pulse_start(v.cfg);
        check({tag, "/busy"}, 36'(busy), 36'd1);
        if (v.rep) begin
            t = 0;
            while (!m_axi_arvalid && t < 300) begin @(negedge ACLK); t++; end
            check({tag, "/ar_wait"}, 36'(t < 300), 36'd1);
            start = 1'b1; cfg_data = {4{$urandom}};
            @(negedge ACLK);
            start = 1'b0;
        end
        t = 0;
        while (!done && t < 500) begin @(negedge ACLK); t++; end
        check({tag, "/done_seen"}, 36'(done), 36'd1);
        check({tag, "/busy_at_done"}, 36'(busy), 36'd0);
        check({tag, "/err"}, 36'(err_cnt), 36'(v.exp_err));
        check({tag, "/pass"}, 36'(pass), 36'(v.exp_err == 0));
        repeat (3) @(negedge ACLK);
        check({tag, "/done_cnt"}, 36'(done_cnt), 36'd1);
        check({tag, "/err_hold"}, 36'(err_cnt), 36'(v.exp_err));
        check({tag, "/pass_hold"}, 36'(pass), 36'(v.exp_err == 0));
        check({tag, "/n_wr"}, 36'(wr_q.size()), 36'd4);
        check({tag, "/n_rd"}, 36'(rd_q.size()), 36'd4);
        if (wr_q.size() == 4 && rd_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                a = 4'(4 * i);
                check($sformatf("%s/wr%0d", tag, i), wr_q[i], {a, v.cfg[32*i +: 32]});
                check($sformatf("%s/rd%0d", tag, i), 36'(rd_q[i]), 36'(a));
            end
        end
        check({tag, "/wvalid_cyc"}, 36'(wv_cyc), 36'(4 * (v.wd + 1)));
        check({tag, "/awvalid_cyc"}, 36'(av_cyc), 36'(4 * (v.awd + 1)));
        check({tag, "/outstanding"}, 36'(ovl), 36'd0);
        check({tag, "/stable"}, 36'(stab_bad), 36'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/busy"}, 36'(busy), 36'd0);
        check({tag, "/done"}, 36'(done), 36'd0);
        check({tag, "/pass"}, 36'(pass), 36'd0);
        check({tag, "/err"}, 36'(err_cnt), 36'd0);
        check({tag, "/valids"}, 36'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 36'd0);
        check({tag, "/readies"}, 36'({m_axi_bready, m_axi_rready}), 36'd0);
    endtask

    vec_t tbl [8];
    vec_t rv;
    localparam logic [127:0] CFG_A = 128'h00000004_00000003_00000002_00000001;

    initial begin
        int t;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        tbl[0] = '{CFG_A, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[1] = '{CFG_A, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 1, 1'b0};
        tbl[2] = '{CFG_A, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[3] = '{CFG_A, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 1'b0};
        tbl[4] = '{CFG_A, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b1};
        tbl[5] = '{CFG_A, 1, 2, 1, 4'b1111, 4'b1111, 4'b1111, 8, 1'b0};
        tbl[6] = '{128'hCAFEBABE_12345678_0000DEAD_FFFFFFFF, 0, 2, 1, 4'b0000, 4'b0010, 4'b0000, 0, 1'b0};
        tbl[7] = '{128'h11111111_22222222_33333333_44444444, 1, 3, 0, 4'b0100, 4'b0000, 4'b1000, 2, 1'b0};

        // Reset state
        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        check("reset/wstrb", 36'(m_axi_wstrb), 36'hF);
        ARESET = 1'b0;
        @(negedge ACLK);
        check_all_zero("idle");

        for (int i = 0; i < 8; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 20; i++) begin
            rv.cfg = {$urandom, $urandom, $urandom, $urandom};
            rv.awd = $urandom_range(0, 3);
            rv.wd  = $urandom_range(0, 3);
            rv.ard = $urandom_range(0, 3);
            rv.be  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rv.rb  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rv.re  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rv.rep = 1'($urandom_range(0, 1));
            rv.exp_err = model_err(rv.cfg, rv.be, rv.rb, rv.re);
            run_vec($sformatf("rnd%0d", i), rv);
        end

        // Leave pass=1, then reset in the middle of the read phase.
        run_vec("pre_rst", tbl[0]);
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        b_err_m = 4'b0001; r_bad_m = '0; r_err_m = '0;
        clear_logs();
        pulse_start(CFG_A);
        t = 0;
        while (!m_axi_rready && t < 300) begin @(negedge ACLK); t++; end
        check("midrst/rready_seen", 36'(m_axi_rready), 36'd1);
        check("midrst/err_before", 36'(err_cnt), 36'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_all_zero("midrst");
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        check("midrst/no_done", 36'(done_cnt), 36'd0);
        run_vec("post_rst", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
